range_counter: RTL and testbench



---
 rtl/range_counter.sv | 210 +++++++++++++++++++++
 tb/tb_range_counter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_counter.sv
// -----------------------------------------------------------------------------
// range_counter
//
// Parametrised modulo range counter. Counts between MIN and MAX (inclusive)
// in steps of STEP, up or down, with enable, clamped synchronous load, a
// one-cycle wrap pulse and a free-running wrap tally.
//
// Optional feature: define RANGE_COUNTER_BOUNCE_EN to compile in ping-pong
// (bounce) mode and its internal direction register. Without the macro the
// bounce input is ignored and the block always runs in wrap mode using dir.
//
// Parameters:
//   WIDTH  counter width in bits
//   MIN    lower bound (inclusive)
//   MAX    upper bound (inclusive)
//   STEP   increment/decrement magnitude
//   WRAPW  width of the wrap tally
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high reset
//   enable      in   advance the counter this cycle
//   dir         in   0 = up, 1 = down (wrap mode only)
//   bounce      in   1 = ping-pong mode (only with RANGE_COUNTER_BOUNCE_EN)
//   load        in   synchronous load request
//   load_value  in   value to load, clamped to [MIN, MAX]
//   counter     out  current count (registered)
//   wrap        out  one-cycle pulse on wrap or reversal (registered)
//   wrap_count  out  wraps since reset, modulo 2^WRAPW (registered)
// -----------------------------------------------------------------------------
module range_counter #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned MIN   = 7,
    parameter int unsigned MAX   = 77,
    parameter int unsigned STEP  = 1,
    parameter int unsigned WRAPW = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             bounce,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             wrap,
    output logic [WRAPW-1:0] wrap_count
);

    // One extra bit so MAX + STEP never overflows near 2^WIDTH-1.
    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);

    if ((MIN >= MAX) ||
        (64'(MAX) > ((64'd1 << WIDTH) - 64'd1)) ||
        (STEP < 32'd1) ||
        (STEP > (MAX - MIN))) begin : g_bad_params
        $fatal(1, "range_counter: illegal WIDTH/MIN/MAX/STEP combination");
    end

    // Wrap-mode step: returns {wrap, next}. Wraps land exactly on the bound.
    function automatic logic [WIDTH:0] wrap_step(input logic [WIDTH:0] cnt_x,
                                                 input logic           down);
        logic [WIDTH:0] sum_x;
        logic [WIDTH:0] res;
        sum_x = cnt_x + STEP_X;
        if (!down) begin
            if (sum_x > MAX_X) begin
                res = {1'b1, MIN_W};
            end else begin
                res = {1'b0, sum_x[WIDTH-1:0]};
            end
        end else begin
            if (cnt_x < (MIN_X + STEP_X)) begin
                res = {1'b1, MAX_W};
            end else begin
                sum_x = cnt_x - STEP_X;
                res   = {1'b0, sum_x[WIDTH-1:0]};
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             wrap_q, wrap_d;
    logic [WRAPW-1:0] wrap_count_q, wrap_count_d;
    logic [WIDTH:0]   wrap_res_s;

    assign wrap_res_s = wrap_step({1'b0, counter_q}, dir);

`ifdef RANGE_COUNTER_BOUNCE_EN
    // Landing points after a reversal, clamped to the opposite bound.
    localparam logic [WIDTH:0] BNC_DN_X = ((MAX_X - STEP_X) < MIN_X) ? MIN_X : (MAX_X - STEP_X);
    localparam logic [WIDTH:0] BNC_UP_X = ((MIN_X + STEP_X) > MAX_X) ? MAX_X : (MIN_X + STEP_X);

    // Bounce-mode step: returns {new_down, wrap, next}. Steps saturate at the
    // bounds and reverse only once the bound itself has been shown.
    function automatic logic [WIDTH+1:0] bounce_step(input logic [WIDTH:0] cnt_x,
                                                     input logic           down);
        logic [WIDTH+1:0] res;
        if (!down) begin
            if (cnt_x == MAX_X) begin
                res = {1'b1, 1'b1, BNC_DN_X[WIDTH-1:0]};
            end else if ((cnt_x + STEP_X) > MAX_X) begin
                res = {1'b0, 1'b0, MAX_W};
            end else begin
                res = {1'b0, 1'b0, WIDTH'(cnt_x + STEP_X)};
            end
        end else begin
            if (cnt_x == MIN_X) begin
                res = {1'b0, 1'b1, BNC_UP_X[WIDTH-1:0]};
            end else if (cnt_x < (MIN_X + STEP_X)) begin
                res = {1'b1, 1'b0, MIN_W};
            end else begin
                res = {1'b1, 1'b0, WIDTH'(cnt_x - STEP_X)};
            end
        end
        return res;
    endfunction

    logic             bnc_down_q, bnc_down_d;
    logic [WIDTH+1:0] bnc_res_s;

    assign bnc_res_s = bounce_step({1'b0, counter_q}, bnc_down_q);
`else
    logic unused_bounce_s;
    assign unused_bounce_s = bounce;
`endif

    // Next-state selection: load > enable > hold (reset handled in the flop block).
    always_comb begin
        counter_d    = counter_q;
        wrap_d       = 1'b0;
        wrap_count_d = wrap_count_q;
`ifdef RANGE_COUNTER_BOUNCE_EN
        bnc_down_d   = bnc_down_q;
`endif
        if (load) begin
            if (load_value < MIN_W) begin
                counter_d = MIN_W;
            end else if (load_value > MAX_W) begin
                counter_d = MAX_W;
            end else begin
                counter_d = load_value;
            end
`ifdef RANGE_COUNTER_BOUNCE_EN
            bnc_down_d = 1'b0;
`endif
        end else if (enable) begin
`ifdef RANGE_COUNTER_BOUNCE_EN
            if (bounce) begin
                bnc_down_d = bnc_res_s[WIDTH+1];
                wrap_d     = bnc_res_s[WIDTH];
                counter_d  = bnc_res_s[WIDTH-1:0];
            end else begin
                // Outside bounce mode the direction is parked at up so that
                // entering bounce mode always starts upward.
                bnc_down_d = 1'b0;
                wrap_d     = wrap_res_s[WIDTH];
                counter_d  = wrap_res_s[WIDTH-1:0];
            end
`else
            wrap_d    = wrap_res_s[WIDTH];
            counter_d = wrap_res_s[WIDTH-1:0];
`endif
        end else begin
`ifdef RANGE_COUNTER_BOUNCE_EN
            if (!bounce) begin
                bnc_down_d = 1'b0;
            end else begin
                bnc_down_d = bnc_down_q;
            end
`endif
            counter_d = counter_q;
        end

        if (wrap_d) begin
            wrap_count_d = wrap_count_q + WRAPW'(1);
        end else begin
            wrap_count_d = wrap_count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q    <= MIN_W;
            wrap_q       <= 1'b0;
            wrap_count_q <= '0;
`ifdef RANGE_COUNTER_BOUNCE_EN
            bnc_down_q   <= 1'b0;
`endif
        end else begin
            counter_q    <= counter_d;
            wrap_q       <= wrap_d;
            wrap_count_q <= wrap_count_d;
`ifdef RANGE_COUNTER_BOUNCE_EN
            bnc_down_q   <= bnc_down_d;
`endif
        end
    end

    assign counter    = counter_q;
    assign wrap       = wrap_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_range_counter.sv
// Self-checking bench for range_counter: a default instance (STEP=1) and a
// STEP=5 instance share stimulus and are checked against an integer model.
module tb_range_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic       bounce = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_value = 7'd0;

    logic [6:0] d_cnt [2];
    logic       d_w   [2];
    logic [7:0] d_wc  [2];

    int n_checks = 0;
    int n_errors = 0;

`ifdef RANGE_COUNTER_BOUNCE_EN
    localparam bit BNC_EN = 1'b1;
`else
    localparam bit BNC_EN = 1'b0;
`endif

    // Reference model state, one slot per instance.
    int steps [2] = '{1, 5};
    int m_cnt [2];
    int m_wc  [2];
    bit m_w   [2];
    bit m_dn  [2];

    always #5 clock = ~clock;

    range_counter dut0 (
        .clock(clock), .reset(reset), .enable(enable), .dir(dir),
        .bounce(bounce), .load(load), .load_value(load_value),
        .counter(d_cnt[0]), .wrap(d_w[0]), .wrap_count(d_wc[0])
    );

    range_counter #(.STEP(5)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .dir(dir),
        .bounce(bounce), .load(load), .load_value(load_value),
        .counter(d_cnt[1]), .wrap(d_w[1]), .wrap_count(d_wc[1])
    );

    // Behavioural model: range 7..77, plain integer arithmetic.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int s;
            bit bm;
            s  = steps[k];
            bm = BNC_EN && bounce;
            m_w[k] = 1'b0;
            if (reset) begin
                m_cnt[k] = 7; m_wc[k] = 0; m_dn[k] = 1'b0;
            end else if (load) begin
                m_cnt[k] = (load_value < 7) ? 7 : ((load_value > 77) ? 77 : int'(load_value));
                m_dn[k]  = 1'b0;
            end else if (enable) begin
                if (bm) begin
                    if (!m_dn[k]) begin
                        if (m_cnt[k] == 77) begin
                            m_dn[k] = 1'b1; m_w[k] = 1'b1;
                            m_cnt[k] = (77 - s < 7) ? 7 : 77 - s;
                        end else begin
                            m_cnt[k] = (m_cnt[k] + s > 77) ? 77 : m_cnt[k] + s;
                        end
                    end else begin
                        if (m_cnt[k] == 7) begin
                            m_dn[k] = 1'b0; m_w[k] = 1'b1;
                            m_cnt[k] = (7 + s > 77) ? 77 : 7 + s;
                        end else begin
                            m_cnt[k] = (m_cnt[k] - s < 7) ? 7 : m_cnt[k] - s;
                        end
                    end
                end else begin
                    m_dn[k] = 1'b0;
                    if (!dir) begin
                        if (m_cnt[k] + s > 77) begin m_cnt[k] = 7; m_w[k] = 1'b1; end
                        else m_cnt[k] = m_cnt[k] + s;
                    end else begin
                        if (m_cnt[k] - s < 7) begin m_cnt[k] = 77; m_w[k] = 1'b1; end
                        else m_cnt[k] = m_cnt[k] - s;
                    end
                end
                if (m_w[k]) m_wc[k] = (m_wc[k] + 1) % 256;
            end else begin
                if (!bm) m_dn[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; enable = 1'b0; dir = 1'b0; bounce = 1'b0;
        tick();
        reset = 1'b0;
        n_checks++;
        if (d_cnt[0] !== 7'd7) begin n_errors++; $display("FAIL reset_cnt: got %0d exp 7", d_cnt[0]); end
        n_checks++;
        if (d_w[0] !== 1'b0) begin n_errors++; $display("FAIL reset_wrap: got %0b exp 0", d_w[0]); end
        n_checks++;
        if (d_wc[0] !== 8'd0) begin n_errors++; $display("FAIL reset_wc: got %0d exp 0", d_wc[0]); end
        n_checks++;
        if (d_cnt[1] !== 7'd7) begin n_errors++; $display("FAIL reset_cnt5: got %0d exp 7", d_cnt[1]); end
    endtask

    task automatic test_count_up();
        enable = 1'b1; dir = 1'b0;
        for (int c = 0; c < 70; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (d_cnt[k] !== 7'(m_cnt[k]) || d_w[k] !== m_w[k] || d_wc[k] !== 8'(m_wc[k])) begin
                    n_errors++;
                    $display("FAIL count_up[%0d] c%0d: got %0d/%0b/%0d exp %0d/%0b/%0d",
                             k, c, d_cnt[k], d_w[k], d_wc[k], m_cnt[k], m_w[k], m_wc[k]);
                end
            end
        end
        n_checks++;
        if (d_cnt[0] !== 7'd77) begin n_errors++; $display("FAIL count_up_end: got %0d exp 77", d_cnt[0]); end
    endtask

    task automatic test_wrap();
        int wc0;
        wc0 = int'(d_wc[0]);
        enable = 1'b1; dir = 1'b0;
        tick();
        n_checks++;
        if (d_cnt[0] !== 7'd7 || d_w[0] !== 1'b1 || d_wc[0] !== 8'(wc0 + 1)) begin
            n_errors++;
            $display("FAIL wrap_up: got %0d/%0b/%0d exp 7/1/%0d", d_cnt[0], d_w[0], d_wc[0], wc0 + 1);
        end
        dir = 1'b1;
        tick();
        n_checks++;
        if (d_cnt[0] !== 7'd77 || d_w[0] !== 1'b1 || d_wc[0] !== 8'(wc0 + 2)) begin
            n_errors++;
            $display("FAIL wrap_down: got %0d/%0b/%0d exp 77/1/%0d", d_cnt[0], d_w[0], d_wc[0], wc0 + 2);
        end
        tick();
        n_checks++;
        if (d_cnt[0] !== 7'd76 || d_w[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL after_wrap: got %0d/%0b exp 76/0", d_cnt[0], d_w[0]);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (d_cnt[0] !== 7'd76 || d_w[0] !== 1'b0 || d_wc[0] !== 8'(wc0 + 2)) begin
            n_errors++;
            $display("FAIL hold: got %0d/%0b/%0d exp 76/0/%0d", d_cnt[0], d_w[0], d_wc[0], wc0 + 2);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (d_cnt[k] !== 7'(m_cnt[k]) || d_wc[k] !== 8'(m_wc[k])) begin
                n_errors++;
                $display("FAIL wrap_model[%0d]: got %0d/%0d exp %0d/%0d", k, d_cnt[k], d_wc[k], m_cnt[k], m_wc[k]);
            end
        end
    endtask

    task automatic test_load();
        int lv [3] = '{100, 3, 40};
        int ex [3] = '{77, 7, 40};
        dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; load_value = 7'(lv[i]); enable = (i == 2);
            tick();
            n_checks++;
            if (d_cnt[0] !== 7'(ex[i]) || d_w[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL load_%0d: got %0d/%0b exp %0d/0", lv[i], d_cnt[0], d_w[0], ex[i]);
            end
        end
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_step5();
        int ld [2] = '{72, 75};
        dir = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load = 1'b1; load_value = 7'(ld[i]); enable = 1'b0;
            tick();
            load = 1'b0; enable = 1'b1;
            tick();
            if (i == 0) begin
                n_checks++;
                if (d_cnt[1] !== 7'd77 || d_w[1] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL step5_72: got %0d/%0b exp 77/0", d_cnt[1], d_w[1]);
                end
                tick();
            end
            n_checks++;
            if (d_cnt[1] !== 7'd7 || d_w[1] !== 1'b1 || d_wc[1] !== 8'(m_wc[1])) begin
                n_errors++;
                $display("FAIL step5_wrap_%0d: got %0d/%0b/%0d exp 7/1/%0d", ld[i], d_cnt[1], d_w[1], d_wc[1], m_wc[1]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_priority();
        enable = 1'b1; load = 1'b1; load_value = 7'd50; reset = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        n_checks++;
        if (d_cnt[0] !== 7'd7 || d_w[0] !== 1'b0 || d_wc[0] !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_priority: got %0d/%0b/%0d exp 7/0/0", d_cnt[0], d_w[0], d_wc[0]);
        end
    endtask

`ifdef RANGE_COUNTER_BOUNCE_EN
    task automatic test_bounce();
        int ex [3] = '{77, 76, 75};
        bit ew [3] = '{1'b0, 1'b1, 1'b0};
        load = 1'b1; load_value = 7'd76;
        tick();
        load = 1'b0; enable = 1'b1; bounce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (d_cnt[0] !== 7'(ex[i]) || d_w[0] !== ew[i]) begin
                n_errors++;
                $display("FAIL bounce_%0d: got %0d/%0b exp %0d/%0b", i, d_cnt[0], d_w[0], ex[i], ew[i]);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (d_cnt[0] !== 7'd7) begin n_errors++; $display("FAIL bounce_reset: got %0d exp 7", d_cnt[0]); end
        tick();
        n_checks++;
        if (d_cnt[0] !== 7'd8) begin n_errors++; $display("FAIL bounce_up_after_reset: got %0d exp 8", d_cnt[0]); end
        bounce = 1'b0; enable = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 59) == 0);
            load       = ($urandom_range(0, 9) == 0);
            enable     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) bounce = ~bounce;
            load_value = 7'($urandom_range(0, 127));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (d_cnt[k] !== 7'(m_cnt[k]) || d_w[k] !== m_w[k] || d_wc[k] !== 8'(m_wc[k])) begin
                    n_errors++;
                    $display("FAIL random[%0d] c%0d: got %0d/%0b/%0d exp %0d/%0b/%0d",
                             k, c, d_cnt[k], d_w[k], d_wc[k], m_cnt[k], m_w[k], m_wc[k]);
                end
            end
        end
        reset = 1'b0; load = 1'b0; enable = 1'b0; bounce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_load();
        test_step5();
        test_reset_priority();
`ifdef RANGE_COUNTER_BOUNCE_EN
        test_bounce();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
